// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: owns the PC, issues one instruction-memory read at a
// time and hands {inst, inst_pc, inst_fault} to decode over valid/ready.
// Redirects from execute replace the PC and mark any in-flight fetch stale;
// halt stops new fetches at the IDLE and HOLD exits.
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_fault
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // Payload presented to decode.
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            fault;
    } inst_pld_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    inst_pld_t       r_pld;
    inst_pld_t       w_pld_nxt;
    logic            r_req_valid;
    logic            w_req_valid_nxt;
    logic            r_inst_valid;
    logic            w_inst_valid_nxt;

    logic            w_accept;
    logic            w_misaligned;

    // A request is only ever presented for an aligned PC, so acceptance
    // needs the registered valid as well as ready.
    assign w_accept     = r_req_valid & imem_req_ready;
    assign w_misaligned = (r_pc[1:0] != 2'b00);

    // State, PC and payload registers; every output comes straight from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_pld        <= '0;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_drop       <= w_drop_nxt;
            r_pld        <= w_pld_nxt;
            r_req_valid  <= w_req_valid_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

    // Next-state, next-PC and payload selection; redirect takes priority in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_drop_nxt  = r_drop;
        w_pld_nxt   = r_pld;

        unique case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (!halt) begin
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    if (w_accept) begin
                        // Old address already went out; its response is stale.
                        w_state_nxt = S_WAIT;
                        w_drop_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else if (w_misaligned) begin
                    // Misaligned PC never reaches memory; report it as a fault.
                    w_pld_nxt.inst  = '0;
                    w_pld_nxt.pc    = r_pc;
                    w_pld_nxt.fault = 1'b1;
                    w_state_nxt     = S_HOLD;
                end else if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    if (imem_rsp_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = halt ? S_IDLE : S_REQ;
                    end else begin
                        w_pld_nxt.inst  = imem_rsp_data;
                        w_pld_nxt.pc    = r_pc;
                        w_pld_nxt.fault = imem_rsp_err;
                        w_state_nxt     = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    // Held entry is retired without advancing the PC.
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = S_REQ;
                end else if (inst_ready) begin
                    w_pc_nxt    = r_pc + XLEN'(4);
                    w_state_nxt = halt ? S_IDLE : S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Valid outputs are registered from the next state, so no input reaches them combinationally.
    always_comb begin
        w_req_valid_nxt  = 1'b0;
        w_inst_valid_nxt = 1'b0;
        if (w_state_nxt == S_REQ) begin
            w_req_valid_nxt = (w_pc_nxt[1:0] == 2'b00);
        end
        if (w_state_nxt == S_HOLD) begin
            w_inst_valid_nxt = 1'b1;
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign inst           = r_pld.inst;
    assign inst_pc        = r_pld.pc;
    assign inst_fault     = r_pld.fault;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed bench for the instruction fetch unit with a small latency-programmable
// instruction-memory responder folded into the cycle-step task.
module tb_ysyx_22050612_ifu;

    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;

    int          n_chk;
    int          n_fail;

    // Memory responder configuration.
    logic        mem_on;
    int          mem_lat;
    logic [31:0] mem_word;
    logic        mem_err;
    logic        pend;
    int          pend_cnt;

    ysyx_22050612_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: note acceptance before the edge, then update the responder #1 after it.
    task automatic tick();
        logic acc;
        acc = imem_req_valid && imem_req_ready;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (mem_on) begin
            if (acc) begin
                pend     = 1'b1;
                pend_cnt = mem_lat;
            end
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend           = 1'b0;
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word;
                    imem_rsp_err   = mem_err;
                end
            end
        end
    endtask

    initial begin
        int ndel;
        n_chk          = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        mem_on         = 1'b0;
        mem_lat        = 1;
        mem_word       = '0;
        mem_err        = 1'b0;
        pend           = 1'b0;
        pend_cnt       = 0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req_valid", 64'(imem_req_valid), 64'd0);
            check("rst_inst_valid", 64'(inst_valid), 64'd0);
        end
        check("rst_inst_pc", inst_pc, 64'd0);
        rst_n = 1'b1;
        tick();
        check("first_req_valid", 64'(imem_req_valid), 64'd1);
        check("first_req_addr", imem_req_addr, 64'h8000_0000);

        // Streaming fetch with an always-ready memory.
        mem_on         = 1'b1;
        mem_lat        = 1;
        mem_word       = 32'h0010_0093;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        tick();
        check("wait_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        check("s2_inst_valid", 64'(inst_valid), 64'd1);
        check("s2_inst", 64'(inst), 64'h0010_0093);
        check("s2_inst_pc", inst_pc, 64'h8000_0000);
        check("s2_inst_fault", 64'(inst_fault), 64'd0);
        tick();
        check("s2_next_addr", imem_req_addr, 64'h8000_0004);
        ndel = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (inst_valid && inst_ready) ndel++;
        end
        check("s2_four_in_12", 64'(ndel), 64'd4);
        check("s2_addr_after", imem_req_addr, 64'h8000_0014);

        // Decode stalls for five cycles in HOLD.
        inst_ready = 1'b0;
        mem_word   = 32'h0020_0113;
        tick();
        tick();
        check("s3_inst_valid", 64'(inst_valid), 64'd1);
        check("s3_inst_pc", inst_pc, 64'h8000_0014);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s3_hold_valid", 64'(inst_valid), 64'd1);
            check("s3_hold_inst", 64'(inst), 64'h0020_0113);
            check("s3_hold_pc", inst_pc, 64'h8000_0014);
            check("s3_hold_fault", 64'(inst_fault), 64'd0);
            check("s3_no_req", 64'(imem_req_valid), 64'd0);
        end
        inst_ready = 1'b1;
        tick();
        check("s3_next_addr", imem_req_addr, 64'h8000_0018);

        // Redirect while waiting; the late response must be dropped.
        mem_lat  = 2;
        mem_word = 32'hdead_beef;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check("s4_wait_inst_valid", 64'(inst_valid), 64'd0);
        check("s4_wait_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        check("s4_drop_inst_valid", 64'(inst_valid), 64'd0);
        check("s4_req_valid", 64'(imem_req_valid), 64'd1);
        check("s4_req_addr", imem_req_addr, 64'h8000_0100);
        mem_lat  = 1;
        mem_word = 32'h0000_0013;
        tick();
        tick();
        check("s4_inst", 64'(inst), 64'h0000_0013);
        check("s4_inst_pc", inst_pc, 64'h8000_0100);
        tick();
        check("s4_next_addr", imem_req_addr, 64'h8000_0104);

        // Misaligned redirect produces a fault without a request.
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check("s5_mis_no_req", 64'(imem_req_valid), 64'd0);
        check("s5_mis_addr", imem_req_addr, 64'h8000_0102);
        tick();
        check("s5_mis_valid", 64'(inst_valid), 64'd1);
        check("s5_mis_fault", 64'(inst_fault), 64'd1);
        check("s5_mis_inst", 64'(inst), 64'd0);
        check("s5_mis_pc", inst_pc, 64'h8000_0102);
        check("s5_mis_no_req2", 64'(imem_req_valid), 64'd0);
        // Redirect out of HOLD while decode is not ready.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        check("s5_hold_redir_valid", 64'(inst_valid), 64'd0);
        check("s5_hold_redir_req", 64'(imem_req_valid), 64'd1);
        check("s5_hold_redir_addr", imem_req_addr, 64'h8000_0200);
        // Memory error on an aligned fetch.
        mem_word = 32'h1234_5678;
        mem_err  = 1'b1;
        tick();
        tick();
        mem_err = 1'b0;
        check("s5_err_fault", 64'(inst_fault), 64'd1);
        check("s5_err_inst", 64'(inst), 64'h1234_5678);
        check("s5_err_pc", inst_pc, 64'h8000_0200);
        inst_ready = 1'b1;
        tick();
        check("s5_err_next", imem_req_addr, 64'h8000_0204);

        // Redirect in the same cycle the request is accepted.
        mem_word       = 32'hdead_beef;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("s5_acc_redir_valid", 64'(inst_valid), 64'd0);
        check("s5_acc_redir_req", 64'(imem_req_valid), 64'd1);
        check("s5_acc_redir_addr", imem_req_addr, 64'h8000_0300);

        // Halt raised during WAIT: the fetch is still delivered, then fetching stops.
        mem_word = 32'h0030_0193;
        tick();
        halt = 1'b1;
        tick();
        check("s6_halt_valid", 64'(inst_valid), 64'd1);
        check("s6_halt_inst", 64'(inst), 64'h0030_0193);
        check("s6_halt_pc", inst_pc, 64'h8000_0300);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s6_idle_req", 64'(imem_req_valid), 64'd0);
            check("s6_idle_inst", 64'(inst_valid), 64'd0);
        end
        halt = 1'b0;
        tick();
        check("s6_resume_req", 64'(imem_req_valid), 64'd1);
        check("s6_resume_addr", imem_req_addr, 64'h8000_0304);

        // Reset pulse in WAIT; the late response lands in IDLE and is ignored.
        mem_lat  = 2;
        mem_word = 32'hbad0_bad0;
        tick();
        rst_n = 1'b0;
        #1;
        check("s6_rst_req", 64'(imem_req_valid), 64'd0);
        check("s6_rst_inst", 64'(inst_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        check("s6_late_rsp_seen", 64'(imem_rsp_valid), 64'd1);
        tick();
        check("s6_restart_req", 64'(imem_req_valid), 64'd1);
        check("s6_restart_addr", imem_req_addr, 64'h8000_0000);
        check("s6_restart_inst", 64'(inst_valid), 64'd0);
        mem_lat  = 1;
        mem_word = 32'h0040_0213;
        tick();
        tick();
        check("s6_refetch_inst", 64'(inst), 64'h0040_0213);
        check("s6_refetch_pc", inst_pc, 64'h8000_0000);
        check("s6_refetch_valid", 64'(inst_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
